add_fp16: RTL and testbench
===========================

Name: add_fp16

Overview:
- Multi-cycle IEEE-754 binary16 adder.
- Sits directly downstream of the FP16 multiplier in the tensor-core MAC datapath: operand a takes the product (multiplier result on its done pulse), operand b takes the partial sum.
- Uses the same start/done handshake as the multiplier, so the two chain without glue logic.
- Fixed 4-cycle latency; non-pipelined; one operation in flight.

Parameters:
- LATENCY, 4, cycles from start-sampling edge to done; fixed by FSM, for bench use only, not overridable.

Ports:
- clk  in  1  system clock, all state on rising edge
- nRST  in  1  reset; asynchronous, active-high (asserted = 1, despite the name)
- start  in  1  request; sampled only in IDLE
- a  in  16  FP16 operand (product from multiplier)
- b  in  16  FP16 operand (accumulator)
- result  out  16  FP16 sum; registered, held until next done
- done  out  1  single-cycle pulse, result valid
- busy  out  1  high from the cycle after capture until done is asserted

Behaviour:
- Reset (nRST=1, async): state=IDLE, result=16'h0000, done=0, busy=0, operand registers cleared.
- Reset mid-operation: in-flight op discarded, no done pulse.
- FSM: IDLE -> ALIGN -> ADD -> NORM -> ROUND -> IDLE, one state per clock.
- IDLE: on a rising edge with start=1, latch a and b, go to ALIGN, set busy.
- ALIGN:
  - Unpack sign, exponent, and 11-bit significand with hidden bit.
  - Swap so the larger magnitude is first.
  - Right-shift the smaller significand by the exponent difference into a 14-bit field: significand + guard + round + sticky.
  - Sticky ORs all bits shifted out.
  - A difference of 14 or more leaves only sticky.
- ADD:
  - Add significands if signs match, else subtract (big minus small).
  - 15-bit result, including carry.
- NORM:
  - On carry, shift right 1 (sticky absorbs the LSB) and increment the exponent.
  - Otherwise, left-shift by the leading-zero count and decrement the exponent.
  - A significand of zero gives exact zero.
- ROUND:
  - Round to nearest, ties to even, using G/R/S.
  - A round carry-out renormalizes (exponent+1).
  - The result register and done are written on the edge leaving ROUND; busy deasserts on that same edge.
- Timing: start sampled at edge N -> done=1 in the cycle following edge N+4, for exactly 1 cycle.
- Throughput: the earliest next accept is edge N+5, which is the edge ending the done cycle (start may be held high).
- start while busy: ignored, not queued.
- Subnormals: inputs with exp=0 are treated as ±0 (flush to zero). Results with exponent < 1 flush to signed zero using the result sign.
- Zero sign: exact cancellation gives +0; (−0)+(−0) gives −0.
- Exponent overflow (>30): see Optional Feature.

Optional Feature:
- Macro: ADD_FP16_SPECIALS_EN.
- Defined, special inputs:
  - Any NaN input -> 16'h7E00.
  - Inf + finite -> that Inf.
  - Inf + Inf (same sign) -> Inf.
  - +Inf + −Inf -> 16'h7E00.
- Defined, overflow -> ±Inf (16'h7C00 / 16'hFC00).
- Latency is unchanged; specials still take 4 cycles.
- Undefined: exponent-31 inputs are treated as ordinary finite values, and overflow saturates to ±max (16'h7BFF / 16'hFBFF).

Test Plan:
- Basic add and latency: a=3C00, b=3C00, start 1 cycle -> result 4000, done exactly 4 cycles after the sampling edge; busy high in between.
- Cancellation: a=4000, b=C000 -> 0000. Then a=8000, b=8000 -> 8000.
- Rounding:
  - 3C00+1400 -> 3C01.
  - 3C00+1000 (tie, even) -> 3C00.
  - 3C01+1000 (tie, odd) -> 3C02.
- Overflow: 7BFF+7BFF -> 7C00 with ADD_FP16_SPECIALS_EN, 7BFF without.
  - With macro, also: 7E00+3C00 -> 7E00; 7C00+FC00 -> 7E00.
- Handshake stress:
  - Hold start=1 for 12 cycles with fixed 3C00+3C00 -> done pulses every 5 cycles, each result 4000.
  - Change a/b while busy -> no effect on the current result.
- Reset mid-op: assert nRST=1 in the NORM cycle -> done never pulses, result=0000 immediately (async). After release, a new op 4400+4400 -> 4800.

Source files
------------

// File: rtl/add_fp16.sv
// add_fp16: multi-cycle IEEE-754 binary16 adder, start/done handshake.
//
// Four-state datapath (ALIGN, ADD, NORM, ROUND) after the IDLE capture;
// done pulses 4 cycles after the edge that samples start. One operation
// in flight; start while busy is ignored.
//
// Ports:
//   clk    in   system clock, rising edge
//   nRST   in   asynchronous reset, active-high despite the name
//   start  in   request, sampled only in IDLE
//   a      in   FP16 operand (product)
//   b      in   FP16 operand (accumulator)
//   result out  FP16 sum, registered, held until next done
//   done   out  one-cycle pulse, result valid
//   busy   out  high from the cycle after capture until done
//
// Build option: ADD_FP16_SPECIALS_EN enables NaN/Inf handling and
// overflow to Inf; otherwise exponent-31 inputs are finite and overflow
// saturates to +/-max. Subnormal inputs/results always flush to zero.

module add_fp16 (
    input  logic        clk,
    input  logic        nRST,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] result,
    output logic        done,
    output logic        busy
);

    typedef enum logic [2:0] {StIdle, StAlign, StAdd, StNorm, StRound} state_e;

    state_e             state_q, state_d;
    logic [15:0]        a_q, a_d, b_q, b_d;
    logic               sign_q, sign_d;
    logic               sub_q, sub_d;
    logic               zero_q, zero_d;
    logic signed [6:0]  exp_q, exp_d;
    logic [13:0]        sig_big_q, sig_big_d, sig_sml_q, sig_sml_d;
    logic [14:0]        sum_q, sum_d;
    logic [15:0]        result_q, result_d;
    logic               done_q, done_d, busy_q, busy_d;
`ifdef ADD_FP16_SPECIALS_EN
    logic               special_q, special_d;
    logic [15:0]        special_val_q, special_val_d;
    logic               a_nan, b_nan, a_inf, b_inf;
`endif

    // Align-stage signals
    logic               swap;
    logic [15:0]        big, sml;
    logic [14:0]        mag_a, mag_b, big_mag, sml_mag;
    logic [10:0]        big_sig, sml_sig;
    logic [4:0]         exp_diff;
    logic [13:0]        sml_field, shifted, lost, aligned;

    // Norm/round-stage signals
    logic [3:0]         lzc;
    logic [13:0]        norm_sig;
    logic signed [6:0]  norm_exp, rnd_exp;
    logic               round_up;
    logic [11:0]        mant_rnd;
    logic [9:0]         frac;
    logic [15:0]        packed_res;

    always_ff @(posedge clk or posedge nRST) begin
        if (nRST) begin
            state_q       <= StIdle;
            a_q           <= 16'h0000;
            b_q           <= 16'h0000;
            sign_q        <= 1'b0;
            sub_q         <= 1'b0;
            zero_q        <= 1'b0;
            exp_q         <= 7'sd0;
            sig_big_q     <= 14'd0;
            sig_sml_q     <= 14'd0;
            sum_q         <= 15'd0;
            result_q      <= 16'h0000;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
`ifdef ADD_FP16_SPECIALS_EN
            special_q     <= 1'b0;
            special_val_q <= 16'h0000;
`endif
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            sign_q        <= sign_d;
            sub_q         <= sub_d;
            zero_q        <= zero_d;
            exp_q         <= exp_d;
            sig_big_q     <= sig_big_d;
            sig_sml_q     <= sig_sml_d;
            sum_q         <= sum_d;
            result_q      <= result_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
`ifdef ADD_FP16_SPECIALS_EN
            special_q     <= special_d;
            special_val_q <= special_val_d;
`endif
        end
    end

    // ALIGN: exp=0 operands read as zero magnitude, so they sort below
    // everything and contribute no significand.
    always_comb begin
        mag_a     = (a_q[14:10] != 5'd0) ? a_q[14:0] : 15'd0;
        mag_b     = (b_q[14:10] != 5'd0) ? b_q[14:0] : 15'd0;
        swap      = mag_b > mag_a;
        big       = swap ? b_q : a_q;
        sml       = swap ? a_q : b_q;
        big_mag   = swap ? mag_b : mag_a;
        sml_mag   = swap ? mag_a : mag_b;
        big_sig   = (big_mag[14:10] != 5'd0) ? {1'b1, big_mag[9:0]} : 11'd0;
        sml_sig   = (sml_mag[14:10] != 5'd0) ? {1'b1, sml_mag[9:0]} : 11'd0;
        exp_diff  = big_mag[14:10] - sml_mag[14:10];
        sml_field = {sml_sig, 3'b000};
        shifted   = sml_field >> exp_diff;
        lost      = sml_field & ~(14'h3fff << exp_diff);
        if (exp_diff >= 5'd14) begin
            aligned = {13'd0, |sml_sig};
        end else begin
            aligned = shifted | {13'd0, |lost};
        end
    end

    // NORM: leading-one search over the low 14 bits (carry handled apart)
    always_comb begin
        lzc = 4'd0;
        for (int i = 0; i < 14; i++) begin
            if (sum_q[i]) lzc = 4'(13 - i);
        end
        if (sum_q[14]) begin
            norm_sig = {sum_q[14:2], sum_q[1] | sum_q[0]};
            norm_exp = exp_q + 7'sd1;
        end else begin
            norm_sig = sum_q[13:0] << lzc;
            norm_exp = exp_q - $signed({3'b000, lzc});
        end
    end

    // ROUND: sum_q[13:0] holds the normalized significand with G/R/S below
    always_comb begin
        round_up = sum_q[2] & (sum_q[3] | sum_q[1] | sum_q[0]);
        mant_rnd = {1'b0, sum_q[13:3]} + {11'd0, round_up};
        rnd_exp  = mant_rnd[11] ? exp_q + 7'sd1 : exp_q;
        frac     = mant_rnd[11] ? mant_rnd[10:1] : mant_rnd[9:0];
        if (zero_q || rnd_exp < 7'sd1) begin
            packed_res = {sign_q, 15'd0};
        end else if (rnd_exp > 7'sd30) begin
`ifdef ADD_FP16_SPECIALS_EN
            packed_res = {sign_q, 15'h7c00};
`else
            packed_res = {sign_q, 15'h7bff};
`endif
        end else begin
            packed_res = {sign_q, rnd_exp[4:0], frac};
        end
`ifdef ADD_FP16_SPECIALS_EN
        if (special_q) packed_res = special_val_q;
`endif
    end

`ifdef ADD_FP16_SPECIALS_EN
    always_comb begin
        a_nan = (&a_q[14:10]) & (|a_q[9:0]);
        b_nan = (&b_q[14:10]) & (|b_q[9:0]);
        a_inf = (&a_q[14:10]) & ~(|a_q[9:0]);
        b_inf = (&b_q[14:10]) & ~(|b_q[9:0]);
    end
`endif

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sign_d    = sign_q;
        sub_d     = sub_q;
        zero_d    = zero_q;
        exp_d     = exp_q;
        sig_big_d = sig_big_q;
        sig_sml_d = sig_sml_q;
        sum_d     = sum_q;
        result_d  = result_q;
        done_d    = 1'b0;
        busy_d    = busy_q;
`ifdef ADD_FP16_SPECIALS_EN
        special_d     = special_q;
        special_val_d = special_val_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    busy_d  = 1'b1;
                    state_d = StAlign;
                end
            end
            StAlign: begin
                sign_d    = big[15];
                sub_d     = big[15] ^ sml[15];
                exp_d     = $signed({2'b00, big_mag[14:10]});
                sig_big_d = {big_sig, 3'b000};
                sig_sml_d = aligned;
`ifdef ADD_FP16_SPECIALS_EN
                special_d     = a_nan | b_nan | a_inf | b_inf;
                special_val_d = (a_nan | b_nan | (a_inf & b_inf & (a_q[15] ^ b_q[15])))
                                ? 16'h7e00 : (a_inf ? a_q : b_q);
`endif
                state_d   = StAdd;
            end
            StAdd: begin
                // Swap guarantees big >= small, so subtraction never wraps
                sum_d   = sub_q ? ({1'b0, sig_big_q} - {1'b0, sig_sml_q})
                                : ({1'b0, sig_big_q} + {1'b0, sig_sml_q});
                state_d = StNorm;
            end
            StNorm: begin
                sum_d  = {1'b0, norm_sig};
                exp_d  = norm_exp;
                zero_d = (sum_q == 15'd0);
                // Exact cancellation is +0; like-signed zeros keep their sign
                if (sum_q == 15'd0 && sub_q) sign_d = 1'b0;
                state_d = StRound;
            end
            StRound: begin
                result_d = packed_res;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign result = result_q;
    assign done   = done_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_add_fp16.sv
// Testbench for add_fp16: directed vectors with literal expectations plus a
// real-arithmetic reference model compared against the outputs every cycle.
module tb_add_fp16;

    localparam int LATENCY = 4;

    logic        clk;
    logic        nRST;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] result;
    logic        done;
    logic        busy;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    add_fp16 dut (
        .clk    (clk),
        .nRST   (nRST),
        .start  (start),
        .a      (a),
        .b      (b),
        .result (result),
        .done   (done),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic real pow2(input int n);
        real r;
        r = 1.0;
        if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
        else for (int i = 0; i < -n; i++) r = r / 2.0;
        return r;
    endfunction

    // Value of an FP16 pattern; exp=0 flushes to zero
    function automatic real to_real(input logic [15:0] h);
        real v;
        int  e;
        e = int'(h[14:10]);
        if (e == 0) return 0.0;
        v = real'(1024 + int'(h[9:0])) * pow2(e - 25);
        return h[15] ? -v : v;
    endfunction

    // Round a nonzero real to FP16 nearest-even, flushing tiny results
    function automatic logic [15:0] from_real(input real v);
        logic       sgn;
        real        m;
        real        rem;
        int         e;
        int         fl;
        logic [4:0] be;
        logic [9:0] fr;
        sgn = (v < 0.0);
        m   = sgn ? -v : v;
        e   = 0;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0) begin m = m * 2.0; e--; end
        m   = m * 1024.0;
        fl  = $rtoi(m);
        rem = m - real'(fl);
        if (rem > 0.5 || (rem == 0.5 && (fl % 2) == 1)) fl++;
        if (fl == 2048) begin fl = 1024; e++; end
        e = e + 15;
        if (e < 1) return {sgn, 15'd0};
`ifdef ADD_FP16_SPECIALS_EN
        if (e > 30) return {sgn, 15'h7c00};
`else
        if (e > 30) return {sgn, 15'h7bff};
`endif
        be = e[4:0];
        fr = fl[9:0];
        return {sgn, be, fr};
    endfunction

    function automatic logic [15:0] model_add(input logic [15:0] x, input logic [15:0] y);
        real s;
`ifdef ADD_FP16_SPECIALS_EN
        bit xn, yn, xi, yi;
        xn = (x[14:10] == 5'h1f) && (x[9:0] != 10'd0);
        yn = (y[14:10] == 5'h1f) && (y[9:0] != 10'd0);
        xi = (x[14:10] == 5'h1f) && (x[9:0] == 10'd0);
        yi = (y[14:10] == 5'h1f) && (y[9:0] == 10'd0);
        if (xn || yn) return 16'h7e00;
        if (xi && yi) return (x[15] != y[15]) ? 16'h7e00 : x;
        if (xi) return x;
        if (yi) return y;
`endif
        s = to_real(x) + to_real(y);
        if (s == 0.0)
            return (x[14:10] == 5'd0 && y[14:10] == 5'd0 && x[15] && y[15]) ? 16'h8000 : 16'h0000;
        return from_real(s);
    endfunction

    // Reference timing/result model: op accepted in idle, result after LATENCY edges
    int          m_phase  = 0;
    logic        m_done   = 1'b0;
    logic        m_busy   = 1'b0;
    logic [15:0] m_result = 16'h0000;
    logic [15:0] m_a      = 16'h0000;
    logic [15:0] m_b      = 16'h0000;

    always @(posedge clk or posedge nRST) begin
        if (nRST) begin
            m_phase  <= 0;
            m_done   <= 1'b0;
            m_busy   <= 1'b0;
            m_result <= 16'h0000;
        end else begin
            m_done <= 1'b0;
            if (m_phase == 0) begin
                if (start) begin
                    m_a     <= a;
                    m_b     <= b;
                    m_phase <= 1;
                    m_busy  <= 1'b1;
                end
            end else if (m_phase < LATENCY) begin
                m_phase <= m_phase + 1;
            end else begin
                m_phase  <= 0;
                m_busy   <= 1'b0;
                m_done   <= 1'b1;
                m_result <= model_add(m_a, m_b);
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc done", {15'd0, done}, {15'd0, m_done});
            check("cyc busy", {15'd0, busy}, {15'd0, m_busy});
            check("cyc result", result, m_result);
        end
    end

    task automatic run_op(input logic [15:0] xa, input logic [15:0] xb,
                          input logic [15:0] exp, input string name);
        int k;
        check({name, " model"}, model_add(xa, xb), exp);
        @(negedge clk);
        a = xa; b = xb; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!done && k < 10) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL %s timeout: no done within 10 cycles", name);
        end else begin
            check({name, " latency"}, 16'(k), 16'(LATENCY));
            check(name, result, exp);
        end
    endtask

    int pulses;
    int e1, e2;

    initial begin
        nRST = 1'b1; start = 1'b0; a = 16'h0000; b = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset result", result, 16'h0000);
        check("reset done", {15'd0, done}, 16'd0);
        check("reset busy", {15'd0, busy}, 16'd0);
        nRST = 1'b0;
        cmp_en = 1'b1;

        run_op(16'h3c00, 16'h3c00, 16'h4000, "1+1");
        run_op(16'h4000, 16'hc000, 16'h0000, "cancel");
        run_op(16'h8000, 16'h8000, 16'h8000, "negzero");
        run_op(16'h3c00, 16'h1400, 16'h3c01, "round up");
        run_op(16'h1400, 16'h3c00, 16'h3c01, "swap order");
        run_op(16'h3c00, 16'h1000, 16'h3c00, "tie even");
        run_op(16'h3c01, 16'h1000, 16'h3c02, "tie odd");
        run_op(16'h3c00, 16'hb800, 16'h3800, "sub norm");
        run_op(16'h4248, 16'hc000, 16'h3c90, "sub frac");
        run_op(16'hc000, 16'h3c00, 16'hbc00, "neg result");
        run_op(16'h7800, 16'h0001, 16'h7800, "subnorm in");
        run_op(16'h0400, 16'h8401, 16'h8000, "flush out");
`ifdef ADD_FP16_SPECIALS_EN
        run_op(16'h7bff, 16'h7bff, 16'h7c00, "overflow");
        run_op(16'h7e00, 16'h3c00, 16'h7e00, "nan");
        run_op(16'h7c00, 16'hfc00, 16'h7e00, "inf-inf");
        run_op(16'h7c00, 16'h3c00, 16'h7c00, "inf+fin");
`else
        run_op(16'h7bff, 16'h7bff, 16'h7bff, "overflow");
        run_op(16'h7c00, 16'h0000, 16'h7bff, "exp31 finite");
`endif

        // Inputs changing while busy must not disturb the captured operands
        @(negedge clk);
        a = 16'h3c00; b = 16'h1400; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; a = 16'hffff; b = 16'h1234;
        for (int k = 0; k < 10 && !done; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("busy inputs", result, 16'h3c01);

        // start held high: one accept every LATENCY+1 cycles
        @(negedge clk);
        a = 16'h3c00; b = 16'h3c00; start = 1'b1;
        pulses = 0; e1 = 0; e2 = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 12) start = 1'b0;
            if (done) begin
                pulses++;
                if (pulses == 1) e1 = i;
                if (pulses == 2) e2 = i;
                check("hold result", result, 16'h4000);
            end
        end
        check("hold pulses", 16'(pulses), 16'd3);
        check("hold first", 16'(e1), 16'd5);
        check("hold gap", 16'(e2 - e1), 16'd5);

        // Reset during NORM: op dropped, outputs cleared at once
        @(negedge clk);
        a = 16'h3c00; b = 16'h3c00; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 nRST = 1'b1;
        #1;
        check("rst result", result, 16'h0000);
        check("rst done", {15'd0, done}, 16'd0);
        check("rst busy", {15'd0, busy}, 16'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 nRST = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) pulses++;
        end
        check("rst no done", 16'(pulses), 16'd0);
        run_op(16'h4400, 16'h4400, 16'h4800, "after rst");

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
